// File: rtl/line_mem.sv
// line_mem: single-port line-wide backing memory with a fixed service latency.
// A requester holds rd_req or wr_req (write wins) until gnt. The request is
// latched on acceptance, serviced after RD_LATENCY / WR_LATENCY cycles, and
// acknowledged with a one-cycle gnt pulse from the DONE state.
//
// Handshake: a request is a level held by the requester. On the IDLE edge
// where it is seen, addr/op/wr_line are captured and later input changes are
// ignored. gnt is high for exactly one cycle (state DONE) and marks completion.
// DONE never accepts, so a request still held through DONE is not serviced
// twice; it is accepted again only on the IDLE edge that follows.
module line_mem #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 7,
  parameter int RD_LATENCY    = 8,
  parameter int WR_LATENCY    = 8,
  localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN,
  localparam int LINE_W       = 32 * LINE_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [LINE_W-1:0]   wr_line,
  output logic [LINE_W-1:0]   rd_line,
  output logic                gnt,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << ADDR_LEN;
  localparam logic [7:0] RD_LAT_M1 = 8'(RD_LATENCY - 1);
  localparam logic [7:0] WR_LAT_M1 = 8'(WR_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                is_wr_q, is_wr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;
  logic                gnt_q, gnt_d;
  logic                mem_we;

  // Storage is deliberately outside the reset domain so rst preserves contents.
  logic [LINE_W-1:0] mem [DEPTH];

  // Next-state, latch capture, latency countdown and completion actions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    line_d    = line_q;
    rd_line_d = rd_line_q;
    gnt_d     = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          addr_d  = addr;
          is_wr_d = 1'b1;
          line_d  = wr_line;
          cnt_d   = WR_LAT_M1;
          state_d = BUSY;
        end else if (rd_req) begin
          addr_d  = addr;
          is_wr_d = 1'b0;
          cnt_d   = RD_LAT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          gnt_d   = 1'b1;
          if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rd_line_d = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and latched registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      line_q    <= '0;
      rd_line_q <= '0;
      gnt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      line_q    <= line_d;
      rd_line_q <= rd_line_d;
      gnt_q     <= gnt_d;
    end
  end

  // Write commit on the BUSY->DONE edge of a write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= line_q;
    end
  end

  assign rd_line   = rd_line_q;
  assign gnt       = gnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_line_mem.sv
// tb_line_mem: directed vectors for line_mem (latency 8) plus hand-written
// sequences for back-to-back, priority, reset abort, input changes after
// acceptance, and a latency-1 instance with a continuously held read.
module tb_line_mem;

  localparam int W = 256;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Latency-8 instance
  logic [6:0]   addr = '0;
  logic         rd_req = 1'b0, wr_req = 1'b0;
  logic [W-1:0] wr_line = '0;
  logic [W-1:0] rd_line;
  logic         gnt;
  logic [1:0]   dbg_state;

  // Latency-1 instance
  logic [6:0]   addr1 = '0;
  logic         rd_req1 = 1'b0, wr_req1 = 1'b0;
  logic [W-1:0] wr_line1 = '0;
  logic [W-1:0] rd_line1;
  logic         gnt1;
  logic [1:0]   dbg_state1;

  line_mem u_dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt), .dbg_state(dbg_state)
  );

  line_mem #(.RD_LATENCY(1), .WR_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .rd_req(rd_req1), .wr_req(wr_req1),
    .wr_line(wr_line1), .rd_line(rd_line1), .gnt(gnt1), .dbg_state(dbg_state1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_line(input logic [31:0] base, input logic [31:0] step);
    logic [W-1:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + step * k;
    return l;
  endfunction

  // Driver: raise a request, wait (bounded) for gnt, report edges to gnt.
  task automatic issue(input bit w, input bit r, input logic [6:0] a,
                       input logic [W-1:0] l, output int cyc);
    bit seen;
    wr_req = w; rd_req = r; addr = a; wr_line = l;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (gnt) seen = 1'b1;
    end
    chk("gnt_timeout", W'(seen), W'(1));
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  typedef struct {
    bit           is_wr;
    logic [6:0]   addr;
    logic [W-1:0] line;
    logic [W-1:0] exp_rd;
    int           exp_cyc;
    string        name;
  } vec_t;

  vec_t vecs[9];

  logic [W-1:0] zero, line_a, line_b, line_c, line_d, line_e, line_f, line_g;
  logic [W-1:0] pat, exp_pat;
  int cyc, highs;
  bit consec;

  initial begin
    zero   = '0;
    line_a = mk_line(32'h0000_0100, 32'd1);
    line_b = mk_line(32'hDEAD_0000, 32'h11);
    line_c = mk_line(32'hFFFF_FFF8, 32'd1);
    line_d = mk_line(32'h55AA_0000, 32'h1000);
    line_e = mk_line(32'h0000_0900, 32'd3);
    line_f = mk_line(32'hBAD0_0000, 32'd1);
    line_g = mk_line(32'h0000_4400, 32'd7);

    vecs[0] = '{1'b0, 7'd5,   zero,   zero,   9, "rd5_zero"};
    vecs[1] = '{1'b1, 7'd3,   line_a, zero,   9, "wr3"};
    vecs[2] = '{1'b0, 7'd3,   zero,   line_a, 9, "rd3"};
    vecs[3] = '{1'b1, 7'd7,   line_b, line_a, 9, "wr7"};
    vecs[4] = '{1'b0, 7'd7,   zero,   line_b, 9, "rd7"};
    vecs[5] = '{1'b0, 7'd3,   zero,   line_a, 9, "rd3_again"};
    vecs[6] = '{1'b1, 7'd127, line_c, line_a, 9, "wr127"};
    vecs[7] = '{1'b0, 7'd127, zero,   line_c, 9, "rd127"};
    vecs[8] = '{1'b0, 7'd0,   zero,   zero,   9, "rd0_zero"};

    // Reset state
    #1;
    chk("rst_gnt", W'(gnt), W'(0));
    chk("rst_rd_line", rd_line, zero);
    chk("rst_state", W'(dbg_state), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven vectors, each started from IDLE
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].is_wr, !vecs[i].is_wr, vecs[i].addr, vecs[i].line, cyc);
      chk({vecs[i].name, "_lat"}, W'(cyc), W'(vecs[i].exp_cyc));
      chk({vecs[i].name, "_rd_line"}, rd_line, vecs[i].exp_rd);
      @(posedge clk); #1;
      chk({vecs[i].name, "_gnt_one_cycle"}, W'(gnt), W'(0));
    end

    // Back-to-back write then read of the same address
    issue(1'b1, 1'b0, 7'd10, line_d, cyc);
    chk("b2b_wr_lat", W'(cyc), W'(9));
    chk("b2b_wr_rd_line_kept", rd_line, zero);
    issue(1'b0, 1'b1, 7'd10, zero, cyc);
    chk("b2b_rd_lat", W'(cyc), W'(10));
    chk("b2b_rd_line", rd_line, line_d);
    @(posedge clk); #1;

    // Simultaneous requests: write first, read stays held through DONE
    issue(1'b1, 1'b1, 7'd9, line_e, cyc);
    chk("prio_wr_lat", W'(cyc), W'(9));
    chk("prio_wr_rd_line_kept", rd_line, line_d);
    issue(1'b0, 1'b1, 7'd9, zero, cyc);
    chk("prio_rd_lat", W'(cyc), W'(10));
    chk("prio_rd_line", rd_line, line_e);
    @(posedge clk); #1;
    chk("prio_gnt_one_cycle", W'(gnt), W'(0));

    // Reset during BUSY aborts a write to addr 2
    wr_req = 1'b1; addr = 7'd2; wr_line = line_f;
    @(posedge clk); #1;
    wr_req = 1'b0;
    chk("abort_busy", W'(dbg_state), W'(1));
    highs = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (gnt) highs++;
    end
    @(posedge clk); #1;
    if (gnt) highs++;
    rst = 1'b1;
    #1;
    chk("abort_rst_gnt", W'(gnt), W'(0));
    chk("abort_rst_rd_line", rd_line, zero);
    chk("abort_rst_state", W'(dbg_state), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (gnt) highs++;
    end
    chk("abort_no_gnt", W'(highs), W'(0));
    issue(1'b0, 1'b1, 7'd2, zero, cyc);
    chk("abort_no_commit", rd_line, zero);
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 7'd3, zero, cyc);
    chk("survive_rst", rd_line, line_a);
    @(posedge clk); #1;

    // Request dropped and addr changed after acceptance
    rd_req = 1'b1; addr = 7'd7;
    @(posedge clk); #1;
    rd_req = 1'b0; addr = 7'd3;
    cyc = 1;
    while (!gnt && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drop_lat", W'(cyc), W'(9));
    chk("drop_rd_line", rd_line, line_b);
    @(posedge clk); #1;

    // Latency-1 instance: write, then continuously held read
    wr_req1 = 1'b1; addr1 = 7'd4; wr_line1 = line_g;
    @(posedge clk); #1;
    chk("lat1_wr_accept_no_gnt", W'(gnt1), W'(0));
    @(posedge clk); #1;
    chk("lat1_wr_gnt", W'(gnt1), W'(1));
    wr_req1 = 1'b0; rd_req1 = 1'b1;
    pat = '0; exp_pat = '0; consec = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      pat[i] = gnt1;
      exp_pat[i] = ((i % 3) == 2);
      if (i > 0 && pat[i] && pat[i-1]) consec = 1'b1;
    end
    rd_req1 = 1'b0;
    chk("lat1_gnt_pattern", pat, exp_pat);
    chk("lat1_no_consecutive", W'(consec), W'(0));
    chk("lat1_rd_line", rd_line1, line_g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_mem.md
LINE_MEM -- requirements
Module: line_mem

Interface
REQ-001 SHALL have parameter LINE_ADDR_LEN, default 3, giving words per line = 2^LINE_ADDR_LEN (LINE_SIZE).
REQ-002 SHALL have parameter ADDR_LEN, default 7, giving line-address width; depth = 2^ADDR_LEN lines.
REQ-003 SHALL have parameter RD_LATENCY, default 8, giving read service time in cycles; legal range 1..255.
REQ-004 SHALL have parameter WR_LATENCY, default 8, giving write service time in cycles; legal range 1..255.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 addr  input  ADDR_LEN  line address ({tag,set} from the cache).
REQ-008 rd_req  input  1  level read request, held by requester until gnt.
REQ-009 wr_req  input  1  level write request, held by requester until gnt.
REQ-010 wr_line  input  32*LINE_SIZE  line to write; word k at bits [32k+31:32k].
REQ-011 rd_line  output  32*LINE_SIZE  last line read; same word packing.
REQ-012 gnt  output  1  one-cycle completion pulse for the accepted request.

Function
REQ-013 Storage SHALL be 2^ADDR_LEN lines x LINE_SIZE 32-bit words, all zero at time zero.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE: on an edge with wr_req=1 SHALL accept a write; else with rd_req=1 SHALL accept a read; else stay IDLE.
REQ-016 On acceptance SHALL latch addr, operation type and (write) wr_line into internal registers, load an 8-bit counter with LAT-1 (LAT = WR_LATENCY or RD_LATENCY), go to BUSY.
REQ-017 Changes to addr, wr_line, rd_req, wr_req after acceptance SHALL be ignored until the operation completes; request withdrawal SHALL NOT abort it.
REQ-018 BUSY: counter SHALL decrement each cycle; on the edge where counter==0 SHALL go to DONE.
REQ-019 On the BUSY->DONE edge a write SHALL commit the latched line to the latched address; a read SHALL load rd_line from the latched address.
REQ-020 gnt SHALL be a registered output, high exactly while in DONE (one cycle), first high LAT cycles after the acceptance edge.
REQ-021 DONE SHALL unconditionally go to IDLE; requests present during DONE SHALL NOT be accepted (prevents double service of a held request).
REQ-022 A request present in IDLE on the edge after DONE SHALL be accepted normally (back-to-back write-then-read supported).
REQ-023 rd_line SHALL hold its value from completion of one read until completion of the next read; writes SHALL NOT alter rd_line, even to the same address.
REQ-024 A read accepted after a write to the same address completes SHALL return the written line.
REQ-025 Simultaneous rd_req and wr_req in IDLE: write SHALL take priority; the read stays pending and is accepted in a later IDLE cycle if still asserted.
REQ-026 Counter arithmetic SHALL be 8-bit unsigned; LAT=1 SHALL give gnt on the cycle immediately after the acceptance edge.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, gnt=0, rd_line=0, counter=0, latched registers=0.
REQ-028 rst SHALL NOT clear the storage array.
REQ-029 rst during BUSY SHALL abort the operation: no write commit, no rd_line update, no gnt.

Verification
REQ-030 Reset then rd_req=1, addr=5, held -> gnt high exactly 8 cycles after acceptance edge for 1 cycle, rd_line=all zeros.
REQ-031 wr_req=1, addr=3, wr_line words k=0x100+k, held to gnt; next cycle rd_req addr=3 -> second gnt, rd_line words 0x100..0x107; rd_line unchanged during the write.
REQ-032 rd_req and wr_req both high, addr=9 -> write serviced first (WR_LATENCY), gnt, one DONE cycle with no acceptance, then read accepted and returns the written line.
REQ-033 Write to addr=2 accepted, rst pulsed 3 cycles later -> no gnt; subsequent read of addr=2 returns zeros (no commit); earlier completed writes elsewhere survive reset.
REQ-034 rd_req dropped and addr changed one cycle after acceptance -> gnt still pulses at LAT; rd_line from original address.
REQ-035 RD_LATENCY=WR_LATENCY=1 instance, rd_req held continuously -> gnt pulses every 3rd cycle, never two consecutive cycles.
